// File: rtl/montgomery_pkg.sv
// Shared types and helpers for the parametrised Montgomery multiplier.
package montgomery_pkg;

    // Controller states: accept, iterate, final reduction, done pulse.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOP   = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Width of the iteration counter that indexes 0..width-1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/montgomery_iter.sv
// One radix-2 Montgomery iteration: c_next = (c + a_bit*b + q*m) / 2.
// Kept separate so the adder chain can later be swapped for carry-save
// or a higher-radix step without touching the controller.
module montgomery_iter
    import montgomery_pkg::*;
#(
    parameter int WIDTH = 512
) (
    input  logic [WIDTH+1:0] c,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    input  logic             a_bit,
    output logic [WIDTH+1:0] c_next
);

    logic [WIDTH+1:0] s;
    logic [WIDTH+1:0] t;

    // c < 2m and b < m keep s + m below 4m, so WIDTH+2 bits never overflow.
    always_comb begin
        s      = c + (a_bit ? {2'b00, b} : '0);
        t      = s + (s[0] ? {2'b00, m} : '0);
        c_next = t >> 1;
    end

endmodule

// File: rtl/montgomery_param.sv
// Bit-serial Montgomery multiplier: result = in_a * in_b * 2^-WIDTH mod in_m.
// One iteration per cycle, then a single conditional subtraction so the
// result is always fully reduced.
module montgomery_param
    import montgomery_pkg::*;
#(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH+1:0] c;
    logic [WIDTH+1:0] c_next;
    logic [CNT_W-1:0] counter;

    // A is shifted right each iteration, so its LSB is always bit 'counter'.
    montgomery_iter #(.WIDTH(WIDTH)) u_iter (
        .c      (c),
        .b      (b_reg),
        .m      (m_reg),
        .a_bit  (a_reg[0]),
        .c_next (c_next)
    );

    // Controller: operand capture, iteration, final reduction, done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            result  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            c       <= '0;
            counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg   <= in_a;
                        b_reg   <= in_b;
                        m_reg   <= in_m;
                        c       <= '0;
                        counter <= '0;
                        busy    <= 1'b1;
                        state   <= LOOP;
                    end
                end
                LOOP: begin
                    c       <= c_next;
                    a_reg   <= a_reg >> 1;
                    counter <= counter + 1'b1;
                    if (counter == CNT_W'(WIDTH - 1))
                        state <= REDUCE;
                end
                REDUCE: begin
                    // c < 2m, so one subtraction brings it below m.
                    if (c >= {2'b00, m_reg})
                        result <= WIDTH'(c - {2'b00, m_reg});
                    else
                        result <= c[WIDTH-1:0];
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
